// File: rtl/mul32_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the sequential 32xB_W multiplier.
//   state_t  : controller states IDLE / RUN / DONE
//   SLICE_W  : width of the multiplier slice fed to MUL_32bit each cycle
//   A_W      : multiplicand width
//   MUL_PP_W : width of the MUL_32bit partial product (A_W + SLICE_W)
//   slice_idx_w() : width of a counter that indexes NSLICE slices
// -----------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W  = 8;
   localparam int A_W      = 32;
   localparam int MUL_PP_W = A_W + SLICE_W;  // 40

   // A one-slice multiplier still needs a 1-bit counter to stay a legal vector.
   function automatic int slice_idx_w(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/mul32_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mul32_seq_ctrl_if
// Operand/result handshake bundle of the sequential multiplier.
//   in_valid/in_ready   : operand handshake, a (32b) and b (B_W b)
//   out_valid/out_ready : result handshake, p (32+B_W b)
//   busy                : multiplier is iterating over slices
// master : the block feeding operands and taking results
// slave  : the multiplier controller
// -----------------------------------------------------------------------------
interface mul32_seq_ctrl_if
   import mul_pkg::*;
#(
   parameter int B_W = 32
);

   logic                 in_valid;
   logic                 in_ready;
   logic [A_W-1:0]       a;
   logic [B_W-1:0]       b;
   logic                 out_valid;
   logic                 out_ready;
   logic [A_W+B_W-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );

endinterface

// File: rtl/mul32_seq_ctrl_mul.sv
// -----------------------------------------------------------------------------
// MUL_32bit
// Combinational unsigned 32x8 array multiplier.
//   A : 32-bit multiplicand
//   B : 8-bit multiplier slice
//   Y : 40-bit product A*B
// Each array row adds the multiplicand, shifted to its bit position, when the
// corresponding multiplier bit is set; the last row is the product.
// -----------------------------------------------------------------------------
module MUL_32bit
   import mul_pkg::*;
(
   input  logic [A_W-1:0]      A,
   input  logic [SLICE_W-1:0]  B,
   output logic [MUL_PP_W-1:0] Y
);

   logic [MUL_PP_W-1:0] row [SLICE_W];

   assign row[0] = B[0] ? MUL_PP_W'(A) : '0;

   for (genvar i = 1; i < SLICE_W; i++) begin : g_row
      logic [MUL_PP_W-1:0] addend;
      assign addend = B[i] ? (MUL_PP_W'(A) << i) : '0;
      assign row[i] = row[i-1] + addend;
   end

   assign Y = row[SLICE_W-1];

endmodule

// File: rtl/mul32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul32_seq_ctrl
// Sequential unsigned 32 x B_W multiplier built around one MUL_32bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul32_seq_ctrl_if
//           in_valid/in_ready/a/b   operand handshake
//           out_valid/out_ready/p   result handshake
//           busy                    high while in RUN
// Operands are captured in IDLE. RUN feeds one 8-bit slice of b per cycle to
// MUL_32bit and accumulates the shifted partial product; it stops after the
// last slice or as soon as the remaining upper slices of b are all zero. DONE
// presents the product until the consumer accepts it.
// -----------------------------------------------------------------------------
module mul32_seq_ctrl
   import mul_pkg::*;
#(
   parameter int B_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mul32_seq_ctrl_if.slave    bus
);

   localparam int NSLICE = B_W / SLICE_W;
   localparam int P_W    = A_W + B_W;
   localparam int K_W    = slice_idx_w(NSLICE);

   state_t              state_q, state_d;
   logic [A_W-1:0]      a_q;
   logic [B_W-1:0]      b_q;
   logic [P_W-1:0]      acc_q;
   logic [P_W-1:0]      p_q;
   logic [K_W-1:0]      k_q;
   logic                init_q;

   logic                in_ready_s;
   logic                accept;
   logic                out_hs;
   logic [SLICE_W-1:0]  slice;
   logic [MUL_PP_W-1:0] pp;
   logic [P_W-1:0]      pp_shifted;
   logic [P_W-1:0]      acc_sum;
   logic [B_W-1:0]      b_rest;
   logic                last_slice;

   // ---------------------------------------------------------------- datapath
   assign slice = SLICE_W'(b_q >> (SLICE_W * int'(k_q)));

   MUL_32bit u_mul (
      .A (a_q),
      .B (slice),
      .Y (pp)
   );

   assign pp_shifted = P_W'(pp) << (SLICE_W * int'(k_q));
   assign acc_sum    = acc_q + pp_shifted;

   // Slices above the current one; once they are all zero the product is final.
   assign b_rest     = b_q >> (SLICE_W * (int'(k_q) + 1));
   assign last_slice = (k_q == K_W'(NSLICE - 1)) || (b_rest == '0);

   // --------------------------------------------------------------- handshake
   // in_ready stays low until the first clock edge after reset release.
   assign in_ready_s = init_q && (state_q == IDLE);
   assign accept     = bus.in_valid && in_ready_s;
   assign out_hs     = (state_q == DONE) && bus.out_ready;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == RUN);
   assign bus.p         = p_q;

   // ------------------------------------------------------------- next state
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and a latch cannot be inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)     state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (out_hs)     state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------- registers
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         k_q     <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q   <= bus.a;
                  b_q   <= bus.b;
                  acc_q <= '0;
                  k_q   <= '0;
               end
            end
            RUN: begin
               acc_q <= acc_sum;
               // p only changes when a new product completes, so the previous
               // result stays visible through the next IDLE and RUN.
               if (last_slice) p_q <= acc_sum;
               else            k_q <= k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul32_seq_ctrl
// Directed bench for mul32_seq_ctrl (B_W = 32): a vector table of operand
// pairs with hand-computed products and RUN lengths, followed by sequences
// for back-pressure, back-to-back operation, reset during RUN and random pairs.
// -----------------------------------------------------------------------------
module tb_mul32_seq_ctrl;

   localparam int B_W = 32;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_p;
      int          exp_r;
   } vec_t;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   mul32_seq_ctrl_if #(.B_W(B_W)) bus ();

   mul32_seq_ctrl #(.B_W(B_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   // Counts edges from the operand handshake until out_valid rises.
   task automatic wait_done(output int r);
      r = 0;
      while (!bus.out_valid && r < 10) begin
         tick();
         r++;
      end
   endtask

   // Full operation: input handshake, RUN length, product, one-cycle out_valid.
   task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_r);
      int r;
      wait_ready(name);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check({name, " busy"}, 64'(bus.busy), 64'd1);
      wait_done(r);
      check({name, " run_cycles"}, 64'(r), 64'(exp_r));
      check({name, " p"}, bus.p, exp_p);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({name, " out_valid_drop"}, 64'(bus.out_valid), 64'd0);
      check({name, " idle_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   vec_t vecs [12];

   initial begin
      logic [63:0] p_hold;
      int          r;
      logic [31:0] ra, rb;
      logic [63:0] rp;
      int          rr;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4};
      vecs[1]  = '{32'h1234_5678, 32'h0000_00FF, 64'h0000_0012_2222_2188, 1};
      vecs[2]  = '{32'hDEAD_BEEF, 32'h0000_0000, 64'h0000_0000_0000_0000, 1};
      vecs[3]  = '{32'h0000_0000, 32'h8000_0000, 64'h0000_0000_0000_0000, 4};
      vecs[4]  = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1};
      vecs[5]  = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 2};
      vecs[6]  = '{32'h8000_0000, 32'h0000_0100, 64'h0000_0080_0000_0000, 2};
      vecs[7]  = '{32'h0000_0001, 32'h00FF_0000, 64'h0000_0000_00FF_0000, 3};
      vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1};
      vecs[9]  = '{32'hABCD_0000, 32'h0000_0002, 64'h0000_0001_579A_0000, 1};
      vecs[10] = '{32'h0000_0007, 32'h0100_0000, 64'h0000_0000_0700_0000, 4};
      vecs[11] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 3};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;

      // ---------------------------------------------------------------- reset
      rst_n = 1'b0;
      #12;
      check("rst in_ready",  64'(bus.in_ready),  64'd0);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst busy",      64'(bus.busy),      64'd0);
      check("rst p",         bus.p,              64'd0);
      #11;
      rst_n = 1'b1;
      #1;
      check("rel in_ready_before_edge", 64'(bus.in_ready), 64'd0);
      tick();
      check("rel in_ready_after_edge", 64'(bus.in_ready), 64'd1);

      // --------------------------------------------------------- vector table
      for (int i = 0; i < 12; i++)
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_r);

      // ------------------------------------------------------- back-pressure
      wait_ready("bp");
      bus.a        = 32'h0001_0000;
      bus.b        = 32'h0001_0000;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_done(r);
      check("bp run_cycles", 64'(r), 64'd3);
      p_hold = bus.p;
      check("bp p", p_hold, 64'h0000_0001_0000_0000);
      for (int c = 0; c < 3; c++) begin
         bus.in_valid = (c != 1);
         bus.a        = 32'h5555_5555;
         bus.b        = 32'h0000_0009;
         tick();
         check($sformatf("bp hold%0d out_valid", c), 64'(bus.out_valid), 64'd1);
         check($sformatf("bp hold%0d in_ready", c),  64'(bus.in_ready),  64'd0);
         check($sformatf("bp hold%0d p", c),         bus.p,              64'h0000_0001_0000_0000);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp release out_valid", 64'(bus.out_valid), 64'd0);
      check("bp release in_ready",  64'(bus.in_ready),  64'd1);
      check("bp release busy",      64'(bus.busy),      64'd0);
      check("bp release p_kept",    bus.p,              64'h0000_0001_0000_0000);

      // -------------------------------------------------------- back-to-back
      bus.a        = 32'h1234_5678;
      bus.b        = 32'h0000_00FF;
      bus.in_valid = 1'b1;
      tick();
      bus.a = 32'h0000_0007;
      bus.b = 32'h0100_0000;
      wait_done(r);
      check("b2b first p", bus.p, 64'h0000_0012_2222_2188);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("b2b gap in_ready", 64'(bus.in_ready), 64'd1);
      check("b2b gap busy",     64'(bus.busy),     64'd0);
      tick();
      bus.in_valid = 1'b0;
      check("b2b second accepted", 64'(bus.busy), 64'd1);
      wait_done(r);
      check("b2b second run_cycles", 64'(r), 64'd4);
      check("b2b second p", bus.p, 64'h0000_0000_0700_0000);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // ---------------------------------------------------- reset during RUN
      wait_ready("rstrun");
      bus.a        = 32'hFFFF_FFFF;
      bus.b        = 32'hFFFF_FFFF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      check("rstrun busy_slice2", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rstrun busy",      64'(bus.busy),      64'd0);
      check("rstrun out_valid", 64'(bus.out_valid), 64'd0);
      check("rstrun p",         bus.p,              64'd0);
      check("rstrun in_ready",  64'(bus.in_ready),  64'd0);
      tick();
      check("rstrun in_ready_held", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b1;
      tick();
      do_op("post_rst", 32'd3, 32'd5, 64'd15, 1);

      // ------------------------------------------------------- random pairs
      for (int i = 0; i < 8; i++) begin
         ra = $urandom();
         rb = $urandom() >> (8 * $urandom_range(0, 3));
         rp = 64'(ra) * 64'(rb);
         rr = 1;
         for (int s = 1; s < 4; s++)
            if ((rb >> (8 * s)) != 0) rr = s + 1;
         do_op($sformatf("rand%0d", i), ra, rb, rp, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
